// File: rtl/udp_tx_frame_buffer.sv
// Packet-mode byte FIFO in front of the UDP/IP transmitter: datagrams are only
// offered once committed, and bad or non-fitting ones are rewound at commit.
module udp_tx_frame_buffer #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned LEN_AW      = 3,
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic              wr_commit,
    output logic              wr_ready,
    output logic              drop_pulse,
    output logic [LEN_AW:0]   pkt_count,
    output logic [15:0]       udp_tx_pending_data,
    output logic [7:0]        udp_tx,
    input  logic              udp_tx_rden
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned LQ_DEPTH = 1 << LEN_AW;
    localparam int unsigned LEN_W    = 11;
    localparam int unsigned PW       = ADDR_W + 1;
    localparam int unsigned FW       = ADDR_W + 2;
    localparam int unsigned QW       = LEN_AW + 1;

    typedef enum logic [1:0] {IDLE, OFFER, DRAIN} state_t;

    state_t state, state_d;

    logic [7:0]       ram  [DEPTH];
    logic [LEN_W-1:0] lenq [LQ_DEPTH];

    logic [PW-1:0]    wr_ptr, rd_ptr, pkt_start;
    logic [PW-1:0]    wr_ptr_d, rd_ptr_d, pkt_start_d, used;
    logic [FW-1:0]    free_d;
    logic [LEN_W-1:0] open_len, open_len_d, eff_len, rem, rem_d, head_len, head_d;
    logic [QW-1:0]    lq_wr, lq_rd, lq_wr_d, lq_rd_d, lq_cnt, lq_cnt_next, pkt_count_d;
    logic             bad, bad_d, bad_eff, ram_full, lq_full, has_data;
    logic             byte_store, push, do_drop, pop, rd_accept, wr_ready_d;
    logic [15:0]      pending_d;

    // Write side: byte acceptance, commit/drop decision and pointer rewind
    always_comb begin
        used        = wr_ptr - rd_ptr;
        ram_full    = (used == PW'(DEPTH));
        lq_cnt      = lq_wr - lq_rd;
        lq_full     = (lq_cnt == QW'(LQ_DEPTH));
        byte_store  = wr_en && !ram_full && (open_len < LEN_W'(MAX_PAYLOAD));
        bad_eff     = bad || (wr_en && !byte_store);
        eff_len     = open_len + LEN_W'(byte_store);
        has_data    = (open_len != '0) || wr_en;
        do_drop     = wr_commit && has_data && (bad_eff || lq_full);
        push        = wr_commit && has_data && !bad_eff && !lq_full;
        wr_ptr_d    = do_drop ? pkt_start : (wr_ptr + PW'(byte_store));
        pkt_start_d = push ? wr_ptr_d : pkt_start;
        lq_wr_d     = lq_wr + QW'(push);
        bad_d       = bad_eff;
        open_len_d  = open_len;
        if (push || do_drop) begin
            bad_d      = 1'b0;
            open_len_d = '0;
        end else if (wr_en && (open_len != LEN_W'(MAX_PAYLOAD + 1))) begin
            open_len_d = open_len + LEN_W'(1);
        end
        // Read pointer taken pre-edge so room is never overstated
        free_d     = FW'(DEPTH) - {1'b0, wr_ptr_d - rd_ptr};
        wr_ready_d = (free_d >= FW'(MAX_PAYLOAD)) &&
                     ((lq_cnt + QW'(push)) < QW'(LQ_DEPTH));
    end

    // Read FSM: next state, head-length pop and byte countdown
    always_comb begin
        state_d     = state;
        rem_d       = rem;
        head_len    = lenq[lq_rd[LEN_AW-1:0]];
        pop         = (state == OFFER) && udp_tx_rden;
        rd_accept   = (state != IDLE) && udp_tx_rden;
        lq_cnt_next = lq_cnt + QW'(push) - QW'(pop);
        case (state)
            IDLE: begin
                if (lq_cnt != '0) state_d = OFFER;
            end
            OFFER: begin
                if (udp_tx_rden) begin
                    rem_d = head_len - LEN_W'(1);
                    if (head_len == LEN_W'(1))
                        state_d = (lq_cnt_next != '0) ? OFFER : IDLE;
                    else
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (udp_tx_rden) begin
                    rem_d = rem - LEN_W'(1);
                    if (rem == LEN_W'(1))
                        state_d = (lq_cnt_next != '0) ? OFFER : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rd_ptr_d = rd_ptr + PW'(rd_accept);
        lq_rd_d  = lq_rd + QW'(pop);
        // A length pushed into an empty queue is forwarded straight to the offer
        head_d   = (push && (lq_wr == lq_rd_d)) ? eff_len : lenq[lq_rd_d[LEN_AW-1:0]];
        pending_d   = (state_d == OFFER) ? 16'(head_d) : 16'h0000;
        pkt_count_d = lq_cnt_next + QW'(state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            pkt_start           <= '0;
            open_len            <= '0;
            bad                 <= 1'b0;
            lq_wr               <= '0;
            lq_rd               <= '0;
            rem                 <= '0;
            wr_ready            <= 1'b0;
            drop_pulse          <= 1'b0;
            pkt_count           <= '0;
            udp_tx_pending_data <= '0;
            udp_tx              <= 8'h00;
        end else begin
            wr_ptr              <= wr_ptr_d;
            rd_ptr              <= rd_ptr_d;
            pkt_start           <= pkt_start_d;
            open_len            <= open_len_d;
            bad                 <= bad_d;
            lq_wr               <= lq_wr_d;
            lq_rd               <= lq_rd_d;
            rem                 <= rem_d;
            wr_ready            <= wr_ready_d;
            drop_pulse          <= do_drop;
            pkt_count           <= pkt_count_d;
            udp_tx_pending_data <= pending_d;
            if (rd_accept) udp_tx <= ram[rd_ptr[ADDR_W-1:0]];
        end
    end

    // Storage arrays carry no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && byte_store) ram[wr_ptr[ADDR_W-1:0]] <= wr_data;
        if (!rst && push)       lenq[lq_wr[LEN_AW-1:0]] <= eff_len;
    end

endmodule
